// File: rtl/clock_set_ctrl_pkg.sv
// clock_pkg: shared types and constants for the clock_set_ctrl slice.
//   mode_t  - controller mode, also presented on the top-level mode port
//   bcd2_t  - two-digit BCD field {tens, digits}
//   *_MAX   - wrap limits of the seconds, minutes and hours fields
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_t;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] digits;
    } bcd2_t;

endpackage

// File: rtl/clock_set_ctrl_bcd2_mod_counter.sv
// bcd2_mod_counter: two-digit BCD counter that wraps from MAX to 00.
//   clk, RST     - clock, synchronous active-high reset
//   clr          - load 00 (wins over inc)
//   inc          - advance by one
//   tens, digits - registered BCD value
//   carry        - high in the cycle whose edge wraps MAX -> 00, so the next
//                  field can advance on that same edge
module bcd2_mod_counter
    import clock_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] digits,
    output logic       carry
);

    bcd2_t val_q;
    logic  at_max;

    // The value only ever counts up from 00, so equality is enough.
    assign at_max = (val_q.tens == 4'(MAX / 10)) && (val_q.digits == 4'(MAX % 10));
    assign carry  = inc && at_max && !clr;

    always_ff @(posedge clk) begin
        if (RST || clr) begin
            val_q <= '0;
        end else if (inc) begin
            if (at_max) begin
                val_q <= '0;
            end else if (val_q.digits == 4'd9) begin
                val_q.tens   <= val_q.tens + 4'd1;
                val_q.digits <= 4'd0;
            end else begin
                val_q.digits <= val_q.digits + 4'd1;
            end
        end
    end

    assign tens   = val_q.tens;
    assign digits = val_q.digits;

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: 24-hour HH:MM:SS counter with RUN / SET_HOUR / SET_MIN
// setting modes and per-digit blink enables for the display driver.
//   clk, RST       - clock, synchronous active-high reset
//   btn_mode       - debounced mode button level (rising edge = event)
//   btn_inc        - debounced increment button level (rising edge = event)
//   sec_tick       - strobe: high for the one cycle in which a RUN-mode
//                    advance is first visible; valid-only, no back-pressure
//   mode           - current FSM state (clock_pkg::mode_t encoding)
//   hour/min/sec   - six registered BCD digits
//   blink_mask     - {ht, hd, mt, md, st, sd}; 1 = blank that digit now
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       sec_tick,
    output logic [1:0] mode,
    output logic [3:0] hour_tens,
    output logic [3:0] hour_digits,
    output logic [3:0] min_tens,
    output logic [3:0] min_digits,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_digits,
    output logic [5:0] blink_mask
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    mode_t         state_q, state_d;
    logic [TW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic [5:0]    mask_d;
    logic          btn_mode_q, btn_inc_q;
    logic          sec_tick_q;

    logic mode_ev, inc_ev, inc_sel;
    logic tick;
    logic sec_clr, sec_carry, min_inc, min_carry, hour_inc;

    // Edge detect; a mode event swallows a coincident increment.
    assign mode_ev = btn_mode && !btn_mode_q;
    assign inc_ev  = btn_inc && !btn_inc_q;
    assign inc_sel = inc_ev && !mode_ev;

    assign tick = (state_q == RUN) && (presc_q == TICK_LAST);

    // Next-state and prescaler / blink next values.
    always_comb begin
        state_d     = state_q;
        presc_d     = '0;
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        mask_d      = '0;

        if (mode_ev) begin
            case (state_q)
                RUN:      state_d = SET_HOUR;
                SET_HOUR: state_d = SET_MIN;
                default:  state_d = RUN;
            endcase
        end

        // Counting only continues while staying in RUN; entering or leaving
        // a setting mode restarts the second from zero.
        if (state_q == RUN && state_d == RUN) begin
            presc_d = tick ? '0 : presc_q + TW'(1);
        end

        // Restarting blink on every mode change keeps the newly selected
        // field visible for a full half-period after entry.
        if (state_d != state_q) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = !phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
            phase_d     = phase_q;
        end

        if (phase_d) begin
            case (state_d)
                SET_HOUR: mask_d = 6'b110000;
                SET_MIN:  mask_d = 6'b001100;
                default:  mask_d = 6'b000000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= RUN;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            blink_mask  <= '0;
            btn_mode_q  <= 1'b0;
            btn_inc_q   <= 1'b0;
            sec_tick_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            blink_mask  <= mask_d;
            btn_mode_q  <= btn_mode;
            btn_inc_q   <= btn_inc;
            sec_tick_q  <= tick;
        end
    end

    // Ripple carries only propagate in RUN; setting a field never touches
    // its neighbour.
    assign sec_clr  = (state_q == SET_MIN) && mode_ev;
    assign min_inc  = sec_carry || ((state_q == SET_MIN) && inc_sel);
    assign hour_inc = ((state_q == RUN) && min_carry) || ((state_q == SET_HOUR) && inc_sel);

    bcd2_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk    (clk),
        .RST    (RST),
        .clr    (sec_clr),
        .inc    (tick),
        .tens   (sec_tens),
        .digits (sec_digits),
        .carry  (sec_carry)
    );

    bcd2_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk    (clk),
        .RST    (RST),
        .clr    (1'b0),
        .inc    (min_inc),
        .tens   (min_tens),
        .digits (min_digits),
        .carry  (min_carry)
    );

    // Day wrap needs no further action, so the hour carry is left open.
    bcd2_mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk    (clk),
        .RST    (RST),
        .clr    (1'b0),
        .inc    (hour_inc),
        .tens   (hour_tens),
        .digits (hour_digits),
        .carry  ()
    );

    assign sec_tick = sec_tick_q;
    assign mode     = state_q;

endmodule
